// File: rtl/branch_sequencer_if.sv
// Bus between decode/ALU and the branch sequencer.
// The BRANCH_STATS_EN macro adds the branch statistics counters.
interface branch_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              instr_valid;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] rs_val;
    logic              alu_zero;
    logic              alu_sign;
    logic              alu_carry;
    logic              flag_we;
    logic              exec_done;
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic              taken;
    logic              link_we;
    logic [ADDR_W-1:0] link_data;
    logic [2:0]        flags_q;
`ifdef BRANCH_STATS_EN
    logic [15:0]       br_total_cnt;
    logic [15:0]       br_taken_cnt;
`endif

    modport master (
        output instr_valid, opcode, offset, rs_val,
        output alu_zero, alu_sign, alu_carry, flag_we, exec_done,
`ifdef BRANCH_STATS_EN
        input  br_total_cnt, br_taken_cnt,
`endif
        input  pc, fetch_req, taken, link_we, link_data, flags_q
    );

    modport slave (
        input  instr_valid, opcode, offset, rs_val,
        input  alu_zero, alu_sign, alu_carry, flag_we, exec_done,
`ifdef BRANCH_STATS_EN
        output br_total_cnt, br_taken_cnt,
`endif
        output pc, fetch_req, taken, link_we, link_data, flags_q
    );
endinterface

// File: rtl/branch_sequencer.sv
// KGP-RISC PC sequencer: owns PC, flags and fetch/decide/execute FSM.
// Define BRANCH_STATS_EN to add saturating branch total/taken counters.
module branch_sequencer #(
    parameter int unsigned              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0,
    parameter int unsigned              PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    branch_sequencer_if.slave bus
);
    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECIDE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;

    localparam logic [5:0] OP_B    = 6'b101000;
    localparam logic [5:0] OP_BR   = 6'b100000;
    localparam logic [5:0] OP_BL   = 6'b101011;
    localparam logic [5:0] OP_BLTZ = 6'b110000;
    localparam logic [5:0] OP_BZ   = 6'b110001;
    localparam logic [5:0] OP_BNZ  = 6'b110010;
    localparam logic [5:0] OP_BCY  = 6'b101001;
    localparam logic [5:0] OP_BNCY = 6'b101010;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [1:0]        state, state_nxt;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] off_q, rs_q;
    logic [ADDR_W-1:0] pc_q, link_data_q, target;
    logic [2:0]        flags;
    logic              taken_q, link_we_q;
    logic              is_branch, cond;

    // Branch classification and condition against the pre-edge flags {zero, sign, carry}
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        state_nxt = state;
        target    = (op_q == OP_BR) ? rs_q : pc_q + off_q;
        case (op_q)
            OP_B, OP_BR, OP_BL: begin is_branch = 1'b1; cond = 1'b1;      end
            OP_BLTZ:            begin is_branch = 1'b1; cond = flags[1];  end
            OP_BZ:              begin is_branch = 1'b1; cond = flags[2];  end
            OP_BNZ:             begin is_branch = 1'b1; cond = ~flags[2]; end
            OP_BCY:             begin is_branch = 1'b1; cond = flags[0];  end
            OP_BNCY:            begin is_branch = 1'b1; cond = ~flags[0]; end
            default:            ;
        endcase
        case (state)
            S_FETCH:  if (bus.instr_valid) state_nxt = S_DECIDE;
            S_DECIDE: state_nxt = is_branch ? S_FETCH : S_EXEC;
            S_EXEC:   if (bus.exec_done) state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            op_q        <= '0;
            off_q       <= '0;
            rs_q        <= '0;
            flags       <= '0;
            taken_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            taken_q   <= 1'b0;
            link_we_q <= 1'b0;
            if (bus.flag_we) flags <= {bus.alu_zero, bus.alu_sign, bus.alu_carry};
            case (state)
                S_FETCH: if (bus.instr_valid) begin
                    op_q  <= bus.opcode;
                    off_q <= bus.offset;
                    rs_q  <= bus.rs_val;
                end
                S_DECIDE: if (is_branch) begin
                    if (cond) begin
                        pc_q    <= target;
                        taken_q <= 1'b1;
                    end else begin
                        pc_q <= pc_q + STEP;
                    end
                    if (op_q == OP_BL) begin
                        link_we_q   <= 1'b1;
                        link_data_q <= pc_q + STEP;
                    end
                end
                S_EXEC: if (bus.exec_done) pc_q <= pc_q + STEP;
                default: ;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] total_cnt, taken_cnt;

    // Saturating counters updated on each branch resolution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cnt <= '0;
            taken_cnt <= '0;
        end else if (state == S_DECIDE && is_branch) begin
            if (total_cnt != 16'hFFFF) total_cnt <= total_cnt + 16'd1;
            if (cond && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
        end
    end

    assign bus.br_total_cnt = total_cnt;
    assign bus.br_taken_cnt = taken_cnt;
`endif

    assign bus.pc        = pc_q;
    assign bus.fetch_req = (state == S_FETCH);
    assign bus.taken     = taken_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
    assign bus.flags_q   = flags;
endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: branch vector table plus
// hand-written sequences for exec wait, flag timing and mid-instruction reset.
module tb_branch_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_sequencer_if #(.ADDR_W(32)) bus ();
    branch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] off;
        logic [31:0] rs;
        logic [2:0]  flg;
        logic [31:0] pc;
        logic        tk;
        logic        lw;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic        lw;
        logic [31:0] ld;
    } exp_t;

    vec_t vecs[15];
    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_flags(input logic [2:0] f);
        @(negedge clk);
        bus.flag_we   = 1'b1;
        bus.alu_zero  = f[2];
        bus.alu_sign  = f[1];
        bus.alu_carry = f[0];
        @(negedge clk);
        bus.flag_we = 1'b0;
    endtask

    // Present one instruction in S_FETCH; returns at the negedge after S_DECIDE
    task automatic issue(input logic [5:0] op, input logic [31:0] off, input logic [31:0] rs);
        int w = 0;
        while (!bus.fetch_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.fetch_req) chk("fetch_wait", 32'(bus.fetch_req), 32'd1);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.offset      = off;
        bus.rs_val      = rs;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.opcode      = 6'b110001;
        bus.offset      = $urandom;
        bus.rs_val      = $urandom;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{6'b101000, 32'h10,       32'h0,    3'b000, 32'h10,   1'b1, 1'b0, 32'h0};
        vecs[1]  = '{6'b110000, 32'h20,       32'h0,    3'b010, 32'h30,   1'b1, 1'b0, 32'h0};
        vecs[2]  = '{6'b110000, 32'h20,       32'h0,    3'b000, 32'h34,   1'b0, 1'b0, 32'h0};
        vecs[3]  = '{6'b101000, 32'hC,        32'h0,    3'b000, 32'h40,   1'b1, 1'b0, 32'h0};
        vecs[4]  = '{6'b101011, 32'hFFFFFFF0, 32'h0,    3'b000, 32'h30,   1'b1, 1'b1, 32'h44};
        vecs[5]  = '{6'b100000, 32'h999,      32'h1234, 3'b000, 32'h1234, 1'b1, 1'b0, 32'h44};
        vecs[6]  = '{6'b110001, 32'h100,      32'h0,    3'b000, 32'h1238, 1'b0, 1'b0, 32'h44};
        vecs[7]  = '{6'b110001, 32'h100,      32'h0,    3'b100, 32'h1338, 1'b1, 1'b0, 32'h44};
        vecs[8]  = '{6'b110010, 32'h100,      32'h0,    3'b000, 32'h1438, 1'b1, 1'b0, 32'h44};
        vecs[9]  = '{6'b110010, 32'h100,      32'h0,    3'b100, 32'h143C, 1'b0, 1'b0, 32'h44};
        vecs[10] = '{6'b101001, 32'h100,      32'h0,    3'b000, 32'h1440, 1'b0, 1'b0, 32'h44};
        vecs[11] = '{6'b101001, 32'h100,      32'h0,    3'b001, 32'h1540, 1'b1, 1'b0, 32'h44};
        vecs[12] = '{6'b101010, 32'h100,      32'h0,    3'b000, 32'h1640, 1'b1, 1'b0, 32'h44};
        vecs[13] = '{6'b101010, 32'h100,      32'h0,    3'b001, 32'h1644, 1'b0, 1'b0, 32'h44};
        vecs[14] = '{6'b101000, 32'hFFFFE9BC, 32'h0,    3'b000, 32'h0,    1'b1, 1'b0, 32'h44};

        rst = 1'b1;
        bus.instr_valid = 1'b0; bus.opcode = '0; bus.offset = '0; bus.rs_val = '0;
        bus.alu_zero = 1'b0; bus.alu_sign = 1'b0; bus.alu_carry = 1'b0;
        bus.flag_we = 1'b0; bus.exec_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_fetch_req", 32'(bus.fetch_req), 32'd1);
        chk("rst_taken", 32'(bus.taken), 32'd0);
        chk("rst_flags", 32'(bus.flags_q), 32'd0);
        rst = 1'b0;

        // Branch table
        for (int i = 0; i < 15; i++) begin
            set_flags(vecs[i].flg);
            chk($sformatf("v%0d_flags", i), 32'(bus.flags_q), 32'(vecs[i].flg));
            sbq.push_back('{vecs[i].pc, vecs[i].tk, vecs[i].lw, vecs[i].ld});
            issue(vecs[i].op, vecs[i].off, vecs[i].rs);
            e = sbq.pop_front();
            chk($sformatf("v%0d_pc", i), bus.pc, e.pc);
            chk($sformatf("v%0d_taken", i), 32'(bus.taken), 32'(e.tk));
            chk($sformatf("v%0d_link_we", i), 32'(bus.link_we), 32'(e.lw));
            chk($sformatf("v%0d_link_data", i), bus.link_data, e.ld);
            chk($sformatf("v%0d_fetch_req", i), 32'(bus.fetch_req), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_taken_pulse", i), 32'(bus.taken), 32'd0);
            chk($sformatf("v%0d_link_pulse", i), 32'(bus.link_we), 32'd0);
        end

        // Non-branch waits for exec_done with pc held
        issue(6'b000000, 32'h40, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("exec_hold_pc", bus.pc, 32'h0);
            chk("exec_hold_fetch", 32'(bus.fetch_req), 32'd0);
            @(negedge clk);
        end
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("exec_done_pc", bus.pc, 32'h4);
        chk("exec_done_fetch", 32'(bus.fetch_req), 32'd1);
        chk("exec_done_taken", 32'(bus.taken), 32'd0);

        // Unlisted 1xxxxx opcode is a non-branch
        issue(6'b100001, 32'h40, 32'h0);
        chk("unlisted_fetch", 32'(bus.fetch_req), 32'd0);
        chk("unlisted_pc", bus.pc, 32'h4);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("unlisted_done_pc", bus.pc, 32'h8);

        // flag_we during S_DECIDE must not affect the current decision
        set_flags(3'b100);
        bus.instr_valid = 1'b1; bus.opcode = 6'b110001; bus.offset = 32'h100;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.flag_we = 1'b1; bus.alu_zero = 1'b0; bus.alu_sign = 1'b0; bus.alu_carry = 1'b0;
        @(negedge clk);
        bus.flag_we = 1'b0;
        chk("flagrace_pc", bus.pc, 32'h108);
        chk("flagrace_taken", 32'(bus.taken), 32'd1);
        chk("flagrace_flags", 32'(bus.flags_q), 32'd0);
        issue(6'b110001, 32'h100, 32'h0);
        chk("flagrace_next_pc", bus.pc, 32'h10C);
        chk("flagrace_next_taken", 32'(bus.taken), 32'd0);

        // Reset in S_EXEC discards the instruction
        set_flags(3'b111);
        issue(6'b000000, 32'h0, 32'h0);
        chk("pre_rst_fetch", 32'(bus.fetch_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", bus.pc, 32'h0);
        chk("mid_rst_flags", 32'(bus.flags_q), 32'd0);
        chk("mid_rst_fetch", 32'(bus.fetch_req), 32'd1);
        chk("mid_rst_link_data", bus.link_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("post_rst_pc", bus.pc, 32'h0);
        chk("post_rst_taken", 32'(bus.taken), 32'd0);
        chk("post_rst_link_we", 32'(bus.link_we), 32'd0);

`ifdef BRANCH_STATS_EN
        chk("stats_rst_total", 32'(bus.br_total_cnt), 32'd0);
        chk("stats_rst_taken", 32'(bus.br_taken_cnt), 32'd0);
        issue(6'b101000, 32'h8, 32'h0);
        chk("stats1_total", 32'(bus.br_total_cnt), 32'd1);
        chk("stats1_taken", 32'(bus.br_taken_cnt), 32'd1);
        issue(6'b110001, 32'h8, 32'h0);
        issue(6'b110010, 32'h8, 32'h0);
        chk("stats3_total", 32'(bus.br_total_cnt), 32'd3);
        chk("stats3_taken", 32'(bus.br_taken_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
